// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial BCD adder/subtractor (ten's complement) with valid/ready handshakes.
// One digit per cycle, least significant first; the result is held until consumed.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int W = 4 * DIGITS;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] a_r, b_r, acc;
    logic [W+3:0] cat;
    logic [4:0] idx, t;
    logic [3:0] bd, digit;
    logic sub_r, carry, bad, bad_nx, carry_nx, last;
    assign bd = sub_r ? 4'd9 - b_r[3:0] : b_r[3:0];
    assign t = {1'b0, a_r[3:0]} + {1'b0, bd} + {4'd0, carry};
    assign carry_nx = t > 5'd9;
    assign digit = carry_nx ? t[3:0] + 4'd6 : t[3:0];
    // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom.
    assign cat = {digit, acc};
    assign bad_nx = bad | (a_r[3:0] > 4'd9) | (b_r[3:0] > 4'd9);
    assign last = idx == 5'(DIGITS - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE && in_valid) state_nx = CALC;
        if (state == CALC && last) state_nx = DONE;
        if (state == DONE && out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            sub_r <= 1'b0;
            carry <= 1'b0;
            bad   <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            sub_r <= sub;
            carry <= sub;
            bad   <= 1'b0;
            idx   <= '0;
        end else if (state == CALC) begin
            a_r   <= a_r >> 4;
            b_r   <= b_r >> 4;
            acc   <= cat[W+3:4];
            carry <= carry_nx;
            bad   <= bad_nx;
            idx   <= idx + 5'd1;
            if (last) begin
                sum  <= bad_nx ? '0 : cat[W+3:4];
                cout <= carry_nx & ~bad_nx;
                err  <= bad_nx;
            end
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: scoreboard bench for bcd_serial_adder; expectations come from
// an integer-arithmetic model of decimal add/subtract.
module tb_bcd_serial_adder;
    localparam int D = 4;
    typedef struct {
        logic [4*D-1:0] s;
        logic c;
        logic e;
        int acc;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, cout, err;
    logic [4*D-1:0] a = '0, b = '0, sum;
    int checks = 0, errors = 0, cyc = 0;
    bit prev_ov = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [4*D-1:0] x, input logic [4*D-1:0] y, input logic s);
        longint ax = 0, by = 0, p = 1, r;
        bit bad = 0;
        exp_t e;
        for (int i = 0; i < D; i++) begin
            if (x[4*i+:4] > 9 || y[4*i+:4] > 9) bad = 1;
            ax += longint'(x[4*i+:4]) * p;
            by += longint'(y[4*i+:4]) * p;
            p *= 10;
        end
        r = s ? ax - by + p : ax + by;
        e.c = !bad && r >= p;
        e.e = bad;
        r = r % p;
        e.s = '0;
        for (int i = 0; i < D; i++) begin
            e.s[4*i+:4] = bad ? 4'd0 : 4'(r % 10);
            r = r / 10;
        end
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [4*D-1:0] rnd_bcd();
        logic [4*D-1:0] v;
        int k;
        for (int i = 0; i < D; i++) v[4*i+:4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, D - 1);
            v[4*k+:4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    // Accepts are predicted from inputs held stable across the negedge before the edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("sum", sum, mon_e.s);
                    chk("cout", cout, mon_e.c);
                    chk("err", err, mon_e.e);
                    chk("latency", 32'(cyc - mon_e.acc), D);
                end
            end
            prev_ov = out_valid;
            if (in_valid && in_ready) begin
                mon_e = model(a, b, sub);
                mon_e.acc = cyc + 1;
                sb.push_back(mon_e);
            end
        end
    end

    task automatic op(input logic [4*D-1:0] x, input logic [4*D-1:0] y, input logic s, input int hold);
        int n;
        logic [4*D-1:0] hs;
        logic hc, he;
        a = x; b = y; sub = s; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0; n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        hs = sum; hc = cout; he = err;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rnd_bcd(); b = rnd_bcd(); sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_sum", sum, hs);
            chk("hold_flags", {cout, err}, {hc, he});
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("exit_idle", {in_ready, out_valid}, 2'b10);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_outs", {in_ready, out_valid, cout, err}, 4'b1000);
        chk("rst_sum", sum, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        op(16'h9999, 16'h0001, 1'b0, 0);
        op(16'h0100, 16'h0001, 1'b1, 0);
        op(16'h0001, 16'h0002, 1'b1, 0);
        // Abort during the second CALC cycle; outputs must clear without a clock edge.
        a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_outs", {in_ready, out_valid, cout, err}, 4'b1000);
        chk("abort_sum", sum, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        op(16'h4567, 16'h5678, 1'b0, 0);
        op(16'h00A0, 16'h0001, 1'b0, 0);
        op(16'h0500, 16'h0250, 1'b1, 10);
        for (int i = 0; i < 40; i++) op(rnd_bcd(), rnd_bcd(), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        repeat (6) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
